// File: rtl/plot_capture_if.sv
// Sample, trigger-control, read-port and status bundle for plot_capture.
interface plot_capture_if #(
    parameter int CHANNELS = 2,
    parameter int ADC_BITS = 12,
    parameter int PV_BITS  = 8,
    parameter int COL_BITS = 9,
    parameter int CH_BITS  = 1
);
    logic                         sample_valid;
    logic [CHANNELS*ADC_BITS-1:0] sample;
    logic [CH_BITS-1:0]           trig_chan;
    logic [ADC_BITS-1:0]          trig_level;
    logic                         trig_slope;
    logic                         rearm;
    logic [COL_BITS-1:0]          rd_col;
    logic [CHANNELS*PV_BITS-1:0]  rd_data;
    logic                         armed;
    logic                         triggered;
    logic                         frozen;

    modport master (
        output sample_valid, sample, trig_chan, trig_level, trig_slope, rearm, rd_col,
        input  rd_data, armed, triggered, frozen
    );

    modport slave (
        input  sample_valid, sample, trig_chan, trig_level, trig_slope, rearm, rd_col,
        output rd_data, armed, triggered, frozen
    );
endinterface

// File: rtl/plot_capture.sv
// Multi-channel scaled waveform capture buffer with column-ordered registered read port.
// PLOT_CAPTURE_TRIGGER_EN defined: level-crossing trigger and freeze; undefined: free-running roll mode.
//   state | meaning
//   FILL  | collecting PRE_TRIG pre-trigger samples, crossings ignored
//   ARMED | writing samples, waiting for a crossing on trig_chan
//   POST  | writing post-trigger samples until the buffer is complete
//   HOLD  | buffer frozen, samples ignored until rearm
module plot_capture #(
    parameter int CHANNELS = 2,
    parameter int ADC_BITS = 12,
    parameter int DEPTH    = 502,
    parameter int PLOT_V   = 151,
    parameter int PRE_TRIG = DEPTH / 2,
    parameter int PV_BITS  = $clog2(PLOT_V),
    parameter int COL_BITS = $clog2(DEPTH),
    parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic           clk,
    input logic           rstn,
    plot_capture_if.slave bus
);
    localparam int W         = CHANNELS * PV_BITS;
    localparam int PROD_BITS = ADC_BITS + $clog2(PLOT_V + 1);
    localparam logic [PROD_BITS-1:0] PLOT_V_W = PROD_BITS'(PLOT_V);
    localparam logic [COL_BITS:0]    DEPTH_W  = (COL_BITS + 1)'(DEPTH);
    localparam logic [COL_BITS-1:0]  LAST_COL = COL_BITS'(DEPTH - 1);

    logic [W-1:0]        mem [DEPTH];
    logic [W-1:0]        wr_data;
    logic [W-1:0]        rd_q;
    logic [COL_BITS-1:0] wp, wp_nxt, start_eff, rd_addr;
    logic [COL_BITS:0]   rd_sum, rd_wrap;
    logic                wr_en, wp_clr;

    always_comb begin
        wr_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [PROD_BITS-1:0] prod;
            prod = PROD_BITS'(bus.sample[c*ADC_BITS +: ADC_BITS]) * PLOT_V_W;
            wr_data[c*PV_BITS +: PV_BITS] = PV_BITS'(prod >> ADC_BITS);
        end
    end

    assign wp_nxt = (wp == LAST_COL) ? '0 : wp + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       wp <= '0;
        else if (wp_clr) wp <= '0;
        else if (wr_en)  wp <= wp_nxt;
    end

`ifdef PLOT_CAPTURE_TRIGGER_EN
    typedef enum logic [1:0] {FILL, ARMED, POST, HOLD} state_t;

    localparam logic [COL_BITS-1:0] FILL_LAST = COL_BITS'(PRE_TRIG - 1);
    localparam logic [COL_BITS-1:0] POST_LOAD = COL_BITS'(DEPTH - PRE_TRIG - 1);

    state_t              state_q, state_d;
    logic [COL_BITS-1:0] fill_cnt, post_cnt, start_q;
    logic [ADC_BITS-1:0] prev_q, cur;
    logic                prev_vld, accept, crossing, fill_done, post_done;

    always_comb begin
        cur = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (bus.trig_chan == CH_BITS'(c)) cur = bus.sample[c*ADC_BITS +: ADC_BITS];
    end

    assign accept    = bus.sample_valid && !bus.rearm && (state_q != HOLD);
    assign crossing  = prev_vld && (bus.trig_slope
                       ? (prev_q > bus.trig_level && cur <= bus.trig_level)
                       : (prev_q < bus.trig_level && cur >= bus.trig_level));
    assign fill_done = (fill_cnt == FILL_LAST);
    assign post_done = (post_cnt == COL_BITS'(1));
    assign wr_en     = accept;
    assign wp_clr    = bus.rearm;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.rearm) begin
            state_d = FILL;
        end else if (accept) begin
            case (state_q)
                FILL:    if (fill_done) state_d = ARMED;
                ARMED:   if (crossing)  state_d = POST;
                POST:    if (post_done) state_d = HOLD;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_cnt <= '0;
            post_cnt <= '0;
            start_q  <= '0;
            prev_q   <= '0;
            prev_vld <= 1'b0;
        end else if (bus.rearm) begin
            fill_cnt <= '0;
            prev_vld <= 1'b0;
        end else if (accept) begin
            prev_q   <= cur;
            prev_vld <= 1'b1;
            if (state_q == FILL) fill_cnt <= fill_cnt + 1'b1;
            if (state_q == ARMED && crossing) post_cnt <= POST_LOAD;
            if (state_q == POST) post_cnt <= post_cnt - 1'b1;
            // wp_nxt is the slot after the last post sample, i.e. the oldest column
            if (state_q == POST && post_done) start_q <= wp_nxt;
        end
    end

    assign start_eff     = (state_q == HOLD) ? start_q : wp;
    assign bus.armed     = (state_q == ARMED);
    assign bus.triggered = (state_q == POST);
    assign bus.frozen    = (state_q == HOLD);
`else
    logic unused_trig;

    assign unused_trig   = ^{bus.rearm, bus.trig_chan, bus.trig_level, bus.trig_slope};
    assign wr_en         = bus.sample_valid;
    assign wp_clr        = 1'b0;
    assign start_eff     = wp;
    assign bus.armed     = 1'b0;
    assign bus.triggered = 1'b0;
    assign bus.frozen    = 1'b0;
`endif

    assign rd_sum  = {1'b0, start_eff} + {1'b0, bus.rd_col};
    assign rd_wrap = rd_sum - DEPTH_W;
    assign rd_addr = (rd_sum >= DEPTH_W) ? rd_wrap[COL_BITS-1:0] : rd_sum[COL_BITS-1:0];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wr_data;
    end

    // Nonblocking read of the same array gives read-first on an address collision
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_q <= '0;
        else       rd_q <= mem[rd_addr];
    end

    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_plot_capture.sv
// Directed bench for plot_capture (DEPTH=8, PRE_TRIG=4); covers trigger or roll build per PLOT_CAPTURE_TRIGGER_EN.
module tb_plot_capture;
    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] d;

    always #5 clk = ~clk;

    plot_capture_if #(.CHANNELS(2), .ADC_BITS(12), .PV_BITS(8), .COL_BITS(3), .CH_BITS(1)) bus ();

    plot_capture #(
        .CHANNELS(2), .ADC_BITS(12), .DEPTH(8), .PLOT_V(151), .PRE_TRIG(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int c0, input int c1, input logic rr);
        @(negedge clk);
        bus.sample       = {12'(c1), 12'(c0)};
        bus.sample_valid = 1'b1;
        bus.rearm        = rr;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.rearm        = 1'b0;
    endtask

    task automatic rd(input int col, output logic [15:0] q);
        @(negedge clk);
        bus.rd_col = 3'(col);
        @(negedge clk);
        q = bus.rd_data;
    endtask

    task automatic check_status(input string tag, input int a, input int t, input int f);
        check({tag, "_armed"}, int'(bus.armed), a);
        check({tag, "_trig"},  int'(bus.triggered), t);
        check({tag, "_frozen"}, int'(bus.frozen), f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef PLOT_CAPTURE_TRIGGER_EN
        int exp_rise[8] = '{3, 7, 11, 36, 110, 110, 110, 110};
        int exp_fall[8] = '{36, 110, 36, 110, 36, 18, 18, 18};
`else
        int exp_roll[8] = '{44, 58, 73, 88, 103, 117, 132, 147};
`endif
        rstn             = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.trig_chan    = 1'b0;
        bus.trig_level   = 12'd2000;
        bus.trig_slope   = 1'b0;
        bus.rearm        = 1'b0;
        bus.rd_col       = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_data", int'(bus.rd_data), 0);
        check_status("reset", 0, 0, 0);
        rstn = 1'b1;

`ifdef PLOT_CAPTURE_TRIGGER_EN
        // rising trigger on ch0
        send(0, 0, 1'b0);
        send(100, 0, 1'b0);
        send(200, 0, 1'b0);
        check_status("fill3", 0, 0, 0);
        send(300, 0, 1'b0);
        check_status("fill4", 1, 0, 0);
        send(1000, 0, 1'b0);
        check_status("armed_nocross", 1, 0, 0);
        send(3000, 0, 1'b0);
        check_status("rise_trig", 0, 1, 0);
        send(3000, 0, 1'b0);
        send(3000, 0, 1'b0);
        check_status("post2", 0, 1, 0);
        send(3000, 0, 1'b0);
        check_status("post3", 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            rd(i, d);
            check($sformatf("rise_col%0d", i), int'(d[7:0]), exp_rise[i]);
        end
        send(4095, 4095, 1'b0);
        rd(0, d);
        check("hold_ignore_col0", int'(d[7:0]), 3);
        rd(7, d);
        check("hold_ignore_col7", int'(d[7:0]), 110);

        // rearm with a coincident sample, then falling slope
        bus.trig_slope = 1'b1;
        send(4095, 0, 1'b1);
        check_status("rearm", 0, 0, 0);
        send(3000, 0, 1'b0);
        send(1000, 0, 1'b0);
        send(3000, 0, 1'b0);
        check_status("rearm_fill3", 0, 0, 0);
        send(1000, 0, 1'b0);
        check_status("fill_done_cross", 1, 0, 0);
        send(3000, 0, 1'b0);
        check_status("fall_wrong_dir", 1, 0, 0);
        send(1000, 0, 1'b0);
        check_status("fall_trig", 0, 1, 0);
        send(500, 0, 1'b0);
        send(500, 0, 1'b0);
        send(500, 0, 1'b0);
        check_status("fall_hold", 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            rd(i, d);
            check($sformatf("fall_col%0d", i), int'(d[7:0]), exp_fall[i]);
        end

        // reset while in POST
        bus.trig_slope = 1'b0;
        send(0, 0, 1'b1);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(3000, 0, 1'b0);
        check_status("post_before_rst", 0, 1, 0);
        rd(7, d);
        check("post_live_col7", int'(d[7:0]), 110);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_rd_data", int'(bus.rd_data), 0);
        check_status("rst_mid_post", 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        check_status("rst_fill3", 0, 0, 0);
        send(0, 0, 1'b0);
        check_status("rst_fill4", 1, 0, 0);

        // scaling on ch1 (buffer is at wp=4, start=wp live while armed)
        send(0, 0, 1'b0);
        send(0, 2048, 1'b0);
        send(0, 4095, 1'b0);
        rd(5, d);
        check("scale_ch1_0", int'(d[15:8]), 0);
        rd(6, d);
        check("scale_ch1_2048", int'(d[15:8]), 75);
        rd(7, d);
        check("scale_ch1_4095", int'(d[15:8]), 150);
`else
        // roll: 10 samples of k*400, rearm and trigger inputs toggled to no effect
        for (int k = 1; k <= 10; k++) begin
            bus.trig_level = 12'(k * 300);
            bus.trig_slope = k[0];
            send(k * 400, 0, (k == 5 || k == 9));
            if (k == 5 || k == 9) check_status($sformatf("roll_s%0d", k), 0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, d);
            check($sformatf("roll_col%0d", i), int'(d[7:0]), exp_roll[i]);
        end

        // read-first: col 0 addresses the slot being overwritten this edge
        @(negedge clk);
        bus.rd_col       = 3'd0;
        bus.sample       = {12'd0, 12'd4095};
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check("read_first_old", int'(bus.rd_data[7:0]), 44);
        rd(7, d);
        check("wrap_newest", int'(d[7:0]), 150);
        rd(0, d);
        check("wrap_oldest", int'(d[7:0]), 58);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_rd_data", int'(bus.rd_data), 0);
        check_status("rst_roll", 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        // scaling: wp restarts at 0, so addrs 0..2 are cols 5..7
        send(100, 0, 1'b0);
        send(200, 2048, 1'b0);
        send(300, 4095, 1'b0);
        rd(5, d);
        check("scale_ch1_0", int'(d[15:8]), 0);
        check("scale_ch0_100", int'(d[7:0]), 3);
        rd(6, d);
        check("scale_ch1_2048", int'(d[15:8]), 75);
        check("scale_ch0_200", int'(d[7:0]), 7);
        rd(7, d);
        check("scale_ch1_4095", int'(d[15:8]), 150);
        check("scale_ch0_300", int'(d[7:0]), 11);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
